// File: rtl/avalon_pkg.sv
// Shared widths and bridge state encoding for the Avalon slave bridge.
package avalon_pkg;

  localparam int unsigned AV_ADDR_W = 30;
  localparam int unsigned AV_BE_W   = 4;
  localparam int unsigned AV_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } bridge_state_e;

endpackage

// File: rtl/av_timeout_counter.sv
// Counts downstream wait cycles; hit flags the cycle whose wait would reach MaxCount.
module av_timeout_counter #(
  parameter int unsigned MaxCount = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic hit
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit = en && (count_q == 16'(MaxCount - 1));

endmodule

// File: rtl/avalon_slave_bridge.sv
// Registered Avalon-MM slave-to-master bridge (IDLE/ISSUE/DONE).
// Optional downstream wait timeout enabled by defining AVALON_BRIDGE_TIMEOUT_EN.
module avalon_slave_bridge
  import avalon_pkg::*;
#(
  parameter int unsigned          TIMEOUT_CYCLES = 255,
  parameter logic [AV_DATA_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [AV_ADDR_W-1:0] i_S_Addr,
  input  logic [AV_BE_W-1:0]   i_S_ByteEn,
  input  logic                 i_S_Read,
  input  logic                 i_S_Write,
  input  logic [AV_DATA_W-1:0] i_S_WriteData,
  output logic [AV_DATA_W-1:0] o_S_ReadData,
  output logic                 o_S_WaitRequest,
  output logic [AV_ADDR_W-1:0] o_M_Addr,
  output logic [AV_BE_W-1:0]   o_M_ByteEn,
  output logic                 o_M_Read,
  output logic                 o_M_Write,
  output logic [AV_DATA_W-1:0] o_M_WriteData,
  input  logic [AV_DATA_W-1:0] i_M_ReadData,
  input  logic                 i_M_WaitRequest,
  output logic                 o_Err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || $bits(TIMEOUT_DATA) != AV_DATA_W) begin : g_bad_cfg
    $error("avalon_slave_bridge: invalid TIMEOUT_CYCLES or TIMEOUT_DATA width");
  end

  bridge_state_e        state_q, state_d;
  logic [AV_ADDR_W-1:0] addr_q, addr_d;
  logic [AV_BE_W-1:0]   be_q, be_d;
  logic [AV_DATA_W-1:0] wdata_q, wdata_d;
  logic [AV_DATA_W-1:0] rdata_q, rdata_d;
  logic                 m_read_q, m_read_d;
  logic                 m_write_q, m_write_d;

`ifdef AVALON_BRIDGE_TIMEOUT_EN
  logic err_q, err_d;
  logic timeout_hit;

  av_timeout_counter #(
    .MaxCount (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .clear (state_q == StIdle),
    .en    ((state_q == StIssue) && i_M_WaitRequest),
    .hit   (timeout_hit)
  );

  assign o_Err = err_q;
`else
  assign o_Err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
`ifdef AVALON_BRIDGE_TIMEOUT_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_S_Read || i_S_Write) begin
          addr_d    = i_S_Addr;
          be_d      = i_S_ByteEn;
          wdata_d   = i_S_WriteData;
          // A simultaneous read and write is treated as a write.
          m_write_d = i_S_Write;
          m_read_d  = i_S_Read && !i_S_Write;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (!i_M_WaitRequest) begin
          if (m_read_q) rdata_d = i_M_ReadData;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = StDone;
`ifdef AVALON_BRIDGE_TIMEOUT_EN
        end else if (timeout_hit) begin
          if (m_read_q) rdata_d = TIMEOUT_DATA;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          err_d     = 1'b1;
          state_d   = StDone;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
`ifdef AVALON_BRIDGE_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
`ifdef AVALON_BRIDGE_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign o_S_WaitRequest = (state_q != StDone);
  assign o_S_ReadData    = rdata_q;
  assign o_M_Addr        = addr_q;
  assign o_M_ByteEn      = be_q;
  assign o_M_Read        = m_read_q;
  assign o_M_Write       = m_write_q;
  assign o_M_WriteData   = wdata_q;

endmodule

// File: tb/tb_avalon_slave_bridge.sv
// Directed self-checking bench for avalon_slave_bridge (timeout cases need AVALON_BRIDGE_TIMEOUT_EN).
module tb_avalon_slave_bridge;

  localparam int unsigned TO = 8;

  logic        clk;
  logic        rst;
  logic [29:0] s_addr;
  logic [3:0]  s_be;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_wait;
  logic [29:0] m_addr;
  logic [3:0]  m_be;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_wait;
  logic        err;

  int checks = 0;
  int errors = 0;

  avalon_slave_bridge #(
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_DATA   (32'hDEAD_BEEF)
  ) dut (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .i_S_Addr        (s_addr),
    .i_S_ByteEn      (s_be),
    .i_S_Read        (s_read),
    .i_S_Write       (s_write),
    .i_S_WriteData   (s_wdata),
    .o_S_ReadData    (s_rdata),
    .o_S_WaitRequest (s_wait),
    .o_M_Addr        (m_addr),
    .o_M_ByteEn      (m_be),
    .o_M_Read        (m_read),
    .o_M_Write       (m_write),
    .o_M_WriteData   (m_wdata),
    .i_M_ReadData    (m_rdata),
    .i_M_WaitRequest (m_wait),
    .o_Err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_req();
    s_read  = 1'b0;
    s_write = 1'b0;
  endtask

  logic [31:0] rd_data [4];

  initial begin
    rst = 1'b1; s_addr = '0; s_be = '0; s_read = 1'b0; s_write = 1'b0; s_wdata = '0;
    m_rdata = '0; m_wait = 1'b0;
    rd_data[0] = 32'h1111_0001; rd_data[1] = 32'h2222_0002;
    rd_data[2] = 32'h3333_0003; rd_data[3] = 32'h4444_0004;

    // Reset state
    cyc(); cyc(); smp();
    check("rst_wait", 32'(s_wait), 32'd1);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_mread", 32'(m_read), 32'd0);
    check("rst_mwrite", 32'(m_write), 32'd0);
    check("rst_maddr", 32'(m_addr), 32'd0);
    check("rst_mbe", 32'(m_be), 32'd0);
    check("rst_mwdata", m_wdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    cyc(); rst = 1'b0;
    smp();
    check("idle_wait", 32'(s_wait), 32'd1);

    // Zero-wait read
    cyc(); s_addr = 30'h10; s_be = 4'hF; s_read = 1'b1; m_wait = 1'b0; m_rdata = 32'h1234_5678;
    smp(); check("rd_n_wait", 32'(s_wait), 32'd1); check("rd_n_mread", 32'(m_read), 32'd0);
    cyc(); smp();
    check("rd_n1_mread", 32'(m_read), 32'd1);
    check("rd_n1_maddr", 32'(m_addr), 32'h10);
    check("rd_n1_wait", 32'(s_wait), 32'd1);
    cyc(); smp();
    check("rd_n2_wait", 32'(s_wait), 32'd0);
    check("rd_n2_rdata", s_rdata, 32'h1234_5678);
    check("rd_n2_mread", 32'(m_read), 32'd0);
    cyc(); idle_req(); m_rdata = 32'h0BAD_0BAD;
    smp(); check("rd_n3_wait", 32'(s_wait), 32'd1);

    // Write with five downstream wait cycles
    cyc(); s_addr = 30'h20; s_be = 4'b0011; s_wdata = 32'hCAFE_F00D; s_write = 1'b1; m_wait = 1'b1;
    smp();
    for (int k = 0; k < 6; k++) begin
      cyc(); m_wait = (k < 5); smp();
      check($sformatf("wr_mwrite%0d", k), 32'(m_write), 32'd1);
      check($sformatf("wr_wdata%0d", k), m_wdata, 32'hCAFE_F00D);
      check($sformatf("wr_wait%0d", k), 32'(s_wait), 32'd1);
    end
    check("wr_be", 32'(m_be), 32'h3);
    check("wr_mread", 32'(m_read), 32'd0);
    cyc(); smp();
    check("wr_done_wait", 32'(s_wait), 32'd0);
    check("wr_done_mwrite", 32'(m_write), 32'd0);
    check("wr_rdata_kept", s_rdata, 32'h1234_5678);
    cyc(); idle_req(); smp();
    check("wr_single_cpl", 32'(s_wait), 32'd1);

    // Read and write together is a write
    cyc(); s_addr = 30'h30; s_be = 4'hF; s_wdata = 32'hA5A5_A5A5; s_read = 1'b1; s_write = 1'b1;
    m_wait = 1'b0;
    smp();
    cyc(); smp();
    check("rw_mwrite", 32'(m_write), 32'd1);
    check("rw_mread", 32'(m_read), 32'd0);
    check("rw_wdata", m_wdata, 32'hA5A5_A5A5);
    cyc(); smp();
    check("rw_done_wait", 32'(s_wait), 32'd0);
    check("rw_rdata_kept", s_rdata, 32'h1234_5678);
    cyc(); idle_req();

    // Reset while the peripheral is stalling a read
    cyc(); s_addr = 30'h40; s_read = 1'b1; m_wait = 1'b1;
    cyc(); smp(); check("rr_mread", 32'(m_read), 32'd1);
    cyc(); rst = 1'b1; idle_req();
    cyc(); smp();
    check("rr_mread_drop", 32'(m_read), 32'd0);
    check("rr_wait", 32'(s_wait), 32'd1);
    check("rr_rdata", s_rdata, 32'd0);
    cyc(); rst = 1'b0; m_wait = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp(); check($sformatf("rr_nocpl%0d", k), 32'(s_wait), 32'd1);
      cyc();
    end

    // Four back-to-back zero-wait reads: one completion every three cycles
    m_wait = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_addr = 30'(32'h100 + 32'(i)); s_read = 1'b1; m_rdata = rd_data[i];
      smp(); check($sformatf("b2b%0d_a_wait", i), 32'(s_wait), 32'd1);
      cyc(); smp();
      check($sformatf("b2b%0d_addr", i), 32'(m_addr), 32'h100 + 32'(i));
      check($sformatf("b2b%0d_b_wait", i), 32'(s_wait), 32'd1);
      cyc(); smp();
      check($sformatf("b2b%0d_cpl", i), 32'(s_wait), 32'd0);
      check($sformatf("b2b%0d_data", i), s_rdata, rd_data[i]);
      cyc();
    end
    idle_req();
    cyc();

`ifdef AVALON_BRIDGE_TIMEOUT_EN
    // Stuck peripheral: abort after TO wait cycles
    s_addr = 30'h50; s_read = 1'b1; m_wait = 1'b1; m_rdata = 32'h5555_5555;
    smp();
    for (int k = 0; k < int'(TO); k++) begin
      cyc(); smp();
      check($sformatf("to_mread%0d", k), 32'(m_read), 32'd1);
      check($sformatf("to_err%0d", k), 32'(err), 32'd0);
    end
    cyc(); smp();
    check("to_wait", 32'(s_wait), 32'd0);
    check("to_rdata", s_rdata, 32'hDEAD_BEEF);
    check("to_err", 32'(err), 32'd1);
    check("to_mread_drop", 32'(m_read), 32'd0);
    cyc(); idle_req(); smp();
    check("to_err_pulse", 32'(err), 32'd0);

    // Completion in the limit cycle is a normal completion
    cyc(); s_addr = 30'h60; s_read = 1'b1; m_wait = 1'b1; m_rdata = 32'h6666_6666;
    smp();
    for (int k = 0; k < int'(TO); k++) begin
      cyc(); m_wait = (k < int'(TO) - 1);
    end
    cyc(); smp();
    check("lim_wait", 32'(s_wait), 32'd0);
    check("lim_rdata", s_rdata, 32'h6666_6666);
    check("lim_err", 32'(err), 32'd0);
    cyc(); idle_req();
`else
    // Without the timeout the bridge waits as long as the peripheral stalls
    s_addr = 30'h50; s_read = 1'b1; m_wait = 1'b1; m_rdata = 32'h5555_5555;
    for (int k = 0; k < 20; k++) begin
      cyc(); smp();
      check($sformatf("nt_wait%0d", k), 32'(s_wait), 32'd1);
    end
    check("nt_mread", 32'(m_read), 32'd1);
    m_wait = 1'b0;
    cyc(); smp();
    check("nt_cpl", 32'(s_wait), 32'd0);
    check("nt_rdata", s_rdata, 32'h5555_5555);
    check("nt_err", 32'(err), 32'd0);
    cyc(); idle_req();
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/avalon_slave_bridge.md
AVALON_SLAVE_BRIDGE -- requirements
Module: avalon_slave_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max downstream wait cycles before abort (range 1..65535).
REQ-002 SHALL have parameter TIMEOUT_DATA, default 32'hDEAD_BEEF: read data returned on an aborted read.
REQ-003 SHALL have port i_Clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have upstream ports (from crossbar slave port): i_S_Addr in 30, i_S_ByteEn in 4, i_S_Read in 1, i_S_Write in 1, i_S_WriteData in 32, o_S_ReadData out 32, o_S_WaitRequest out 1.
REQ-006 SHALL have downstream ports (to peripheral): o_M_Addr out 30, o_M_ByteEn out 4, o_M_Read out 1, o_M_Write out 1, o_M_WriteData out 32, i_M_ReadData in 32, i_M_WaitRequest in 1.
REQ-007 SHALL have port o_Err, output, 1: one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-008 SHALL implement states IDLE, ISSUE, DONE; every downstream output driven from a register (full timing cut).
REQ-009 IDLE: on i_S_Read or i_S_Write high, capture Addr/ByteEn/WriteData/Read/Write into registers; next state ISSUE.
REQ-010 Read and Write both high in IDLE SHALL be captured as a write only (read ignored).
REQ-011 ISSUE: o_M_Read/o_M_Write SHALL equal captured command; when i_M_WaitRequest low, capture i_M_ReadData (reads only), deassert o_M_Read/o_M_Write next cycle, next state DONE.
REQ-012 DONE: o_S_WaitRequest low for exactly one cycle, o_S_ReadData = captured data; next state IDLE unconditionally.
REQ-013 o_S_WaitRequest SHALL be high in every state except DONE, including IDLE with no request.
REQ-014 Minimum latency: request seen in IDLE at cycle N, downstream command at N+1, zero-wait peripheral gives completion (o_S_WaitRequest low) at N+2.
REQ-015 o_S_ReadData SHALL update only on read completion or read timeout; writes leave it unchanged.
REQ-016 Upstream deasserting its request during ISSUE/DONE (protocol violation) SHALL NOT abort the downstream transfer; bridge finishes and returns to IDLE.
REQ-017 A new request present in the cycle after DONE SHALL be accepted from IDLE normally (back-to-back, 3 cycles/transfer best case).

Reset
REQ-018 i_Rst SHALL force IDLE, o_S_WaitRequest=1, o_S_ReadData=0, o_M_Read=0, o_M_Write=0, o_M_Addr/ByteEn/WriteData=0, o_Err=0, timeout counter=0.
REQ-019 Reset mid-ISSUE SHALL drop the downstream command the following cycle with no completion returned upstream.

Configuration
REQ-020 With AVALON_BRIDGE_TIMEOUT_EN defined: counter increments each ISSUE cycle with i_M_WaitRequest high; on reaching TIMEOUT_CYCLES, deassert downstream command, enter DONE with o_S_ReadData=TIMEOUT_DATA (reads) and pulse o_Err.
REQ-021 Without AVALON_BRIDGE_TIMEOUT_EN: no counter, ISSUE waits indefinitely, o_Err tied 0, TIMEOUT_* unused.
REQ-022 Counter SHALL clear on entry to ISSUE; completion in the same cycle as the limit SHALL count as normal completion (no o_Err).

Structure
REQ-023 Shared package avalon_pkg SHALL hold AV_ADDR_W=30, AV_BE_W=4, AV_DATA_W=32 and the bridge state enum.
REQ-024 Timeout counter SHALL be sub-module av_timeout_counter, instantiated only under AVALON_BRIDGE_TIMEOUT_EN.

Verification
REQ-025 Read addr 0x0000010, zero-wait peripheral returning 0x12345678 -> o_M_Read high 1 cycle, o_S_WaitRequest low at request+2, o_S_ReadData=0x12345678.
REQ-026 Write 0xCAFEF00D, ByteEn 4'b0011, peripheral wait 5 cycles -> o_M_Write held 6 cycles with stable data, single upstream completion, o_S_ReadData unchanged.
REQ-027 Macro on, TIMEOUT_CYCLES=8, peripheral WaitRequest stuck high, read -> abort after 8 wait cycles, o_S_ReadData=0xDEADBEEF, o_Err 1-cycle pulse.
REQ-028 Read and Write both high with WriteData 0xA5A5A5A5 -> only o_M_Write asserted, o_M_WriteData=0xA5A5A5A5.
REQ-029 i_Rst asserted during ISSUE with peripheral waiting -> next cycle o_M_Read=0, state IDLE, no o_S_WaitRequest low pulse.
REQ-030 Four back-to-back zero-wait reads -> completions exactly 3 cycles apart, data in order.
